// File: rtl/muldiv_hilo.sv
// Iterative multiply/divide unit owning the HI/LO register pair (shift-add multiply, restoring divide).
// Optional define MULDIV_DIV0_FLAG_EN adds a div0 output and a short-cut divide-by-zero path.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO
`ifdef MULDIV_DIV0_FLAG_EN
  ,
  output logic             div0
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_op;
  logic               r_negQ;
  logic               r_negR;
  logic               r_div0;
  logic [WIDTH-1:0]   r_aRaw;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
`ifdef MULDIV_DIV0_FLAG_EN
  logic               r_div0Out;
`endif

  logic               w_aNeg;
  logic               w_bNeg;
  logic [WIDTH-1:0]   w_aMag;
  logic [WIDTH-1:0]   w_bMag;
  logic               w_bZero;
  logic [WIDTH:0]     w_mulAdd;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_divCand;
  logic [WIDTH:0]     w_divTrial;
  logic               w_divOk;
  logic [2*WIDTH-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_aNeg  = sign & A[WIDTH-1];
  assign w_bNeg  = sign & B[WIDTH-1];
  assign w_aMag  = w_aNeg ? (~A + 1'b1) : A;
  assign w_bMag  = w_bNeg ? (~B + 1'b1) : B;
  assign w_bZero = (B == '0);

  // Multiply: upper half accumulates the multiplicand when the multiplier LSB is set, then all shifts right.
  assign w_mulAdd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mulNext = {w_mulAdd, r_acc[WIDTH-1:1]};

  // Divide: remainder in the upper half, quotient bits shift in from the bottom.
  assign w_divCand  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_divTrial = w_divCand - {1'b0, r_opnd};
  assign w_divOk    = ~w_divTrial[WIDTH];
  assign w_divNext  = {(w_divOk ? w_divTrial[WIDTH-1:0] : w_divCand[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_divOk};

  assign w_prod = r_negQ ? (~r_acc + 1'b1) : r_acc;
  assign w_quot = r_negQ ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem  = r_negR ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_op    <= 1'b0;
      r_negQ  <= 1'b0;
      r_negR  <= 1'b0;
      r_div0  <= 1'b0;
      r_aRaw  <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
      r_div0Out <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef MULDIV_DIV0_FLAG_EN
      r_div0Out <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (mthi) r_hi <= wr_data;
          if (mtlo) r_lo <= wr_data;
          if (start) begin
            r_op    <= op;
            r_negQ  <= w_aNeg ^ w_bNeg;
            r_negR  <= w_aNeg;
            r_div0  <= op & w_bZero;
            r_aRaw  <= A;
            r_opnd  <= op ? w_bMag : w_aMag;
            r_acc   <= {{WIDTH{1'b0}}, (op ? w_aMag : w_bMag)};
            r_count <= '0;
            r_busy  <= 1'b1;
`ifdef MULDIV_DIV0_FLAG_EN
            r_state <= (op && w_bZero) ? FIX : RUN;
`else
            r_state <= RUN;
`endif
          end
        end
        RUN: begin
          r_acc   <= r_op ? w_divNext : w_mulNext;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) r_state <= FIX;
        end
        FIX: begin
          // Divide by zero reports all-ones quotient and the untouched dividend, whatever the sign mode.
          if (!r_op) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end else if (r_div0) begin
            r_hi <= r_aRaw;
            r_lo <= '1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
`ifdef MULDIV_DIV0_FLAG_EN
          r_div0Out <= r_op & r_div0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign outHI = r_hi;
  assign outLO = r_lo;
`ifdef MULDIV_DIV0_FLAG_EN
  assign div0  = r_div0Out;
`endif

endmodule
